// File: rtl/pipeimem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory image loader.
// ROM_* constants are also consumed by the instruction ROM so the depths match.
package pipeimem_loader_pkg;

  localparam int unsigned ROM_ADDR_BITS = 6;
  localparam int unsigned ROM_DEPTH     = 1 << ROM_ADDR_BITS;
  localparam int unsigned ROM_WIDTH     = 32;
  localparam int unsigned BYTE_W        = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/pipeimem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
interface pipeimem_loader_if;
  import pipeimem_loader_pkg::*;

  logic [BYTE_W-1:0] byte_in;
  logic              byte_valid;
  logic              byte_ready;

  modport master (output byte_in, output byte_valid, input  byte_ready);
  modport slave  (input  byte_in, input  byte_valid, output byte_ready);

endinterface

// File: rtl/pipeimem_loader_word_pack.sv
// Packs MSB-first bytes into 32-bit words and keeps the running XOR checksum.
module loader_word_pack
  import pipeimem_loader_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 byte_en,
  input  logic [BYTE_W-1:0]    byte_in,
  output logic                 word_ready_c,
  output logic [ROM_WIDTH-1:0] word_c,
  output logic [BYTE_W-1:0]    acc
);

  localparam int unsigned SHIFT_W = ROM_WIDTH - BYTE_W;

  logic [SHIFT_W-1:0] shift_q;
  logic [1:0]         byte_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_q  <= '0;
      byte_cnt <= '0;
      acc      <= '0;
    end else if (clear) begin
      shift_q  <= '0;
      byte_cnt <= '0;
      acc      <= '0;
    end else if (byte_en) begin
      shift_q  <= {shift_q[SHIFT_W-BYTE_W-1:0], byte_in};
      byte_cnt <= byte_cnt + 2'd1;
      acc      <= acc ^ byte_in;
    end
  end

  // The word completes with the byte currently on the input.
  assign word_ready_c = byte_en && (byte_cnt == 2'd3);
  assign word_c       = {shift_q, byte_in};

endmodule

// File: rtl/pipeimem_loader.sv
// Loads a length-framed, XOR-checksummed program image into instruction memory
// and holds the CPU in reset until a complete, verified image is present.
module pipeimem_loader
  import pipeimem_loader_pkg::*;
#(
  parameter int unsigned ADDR_DEPTH = ROM_ADDR_BITS,
  parameter int unsigned WORD_WIDTH = ROM_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  pipeimem_loader_if.slave      stream,
  output logic                  wr_en,
  output logic [31:0]           wr_addr,
  output logic [WORD_WIDTH-1:0] wr_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_DEPTH:0]   word_count
);

  localparam int unsigned CNT_W = ADDR_DEPTH + 1;
  localparam int unsigned LEN_W = 2 * BYTE_W;
  localparam logic [LEN_W-1:0] MAX_WORDS = LEN_W'(1 << ADDR_DEPTH);

  state_t               state;
  logic                 ready_q;
  logic [BYTE_W-1:0]    len_hi;
  logic [CNT_W-1:0]     len_words;
  logic [LEN_W-1:0]     len_c;
  logic                 xfer_c;
  logic                 start_ok_c;
  logic                 pack_en_c;
  logic                 word_ready_c;
  logic [ROM_WIDTH-1:0] word_c;
  logic [BYTE_W-1:0]    acc;

  assign stream.byte_ready = ready_q;
  assign xfer_c     = stream.byte_valid && ready_q;
  assign start_ok_c = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
  assign pack_en_c  = xfer_c && (state == ST_DATA);
  assign len_c      = {len_hi, stream.byte_in};

  loader_word_pack u_pack (
    .clock        (clock),
    .reset        (reset),
    .clear        (start_ok_c),
    .byte_en      (pack_en_c),
    .byte_in      (stream.byte_in),
    .word_ready_c (word_ready_c),
    .word_c       (word_c),
    .acc          (acc)
  );

  // Frame sequencer; byte_ready is updated together with the state it decodes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      ready_q    <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      len_hi     <= '0;
      len_words  <= '0;
    end else begin
      wr_en <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state      <= ST_LEN_HI;
            ready_q    <= 1'b1;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
          end
        end
        ST_LEN_HI: begin
          if (xfer_c) begin
            len_hi <= stream.byte_in;
            state  <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (xfer_c) begin
            if (len_c == '0 || len_c > MAX_WORDS) begin
              state   <= ST_ERR;
              ready_q <= 1'b0;
              error   <= 1'b1;
            end else begin
              state     <= ST_DATA;
              len_words <= CNT_W'(len_c);
            end
          end
        end
        ST_DATA: begin
          if (word_ready_c) begin
            wr_en      <= 1'b1;
            wr_addr    <= 32'({word_count, 2'b00});
            wr_data    <= WORD_WIDTH'(word_c);
            word_count <= word_count + CNT_W'(1);
            if (word_count + CNT_W'(1) == len_words) state <= ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (xfer_c) begin
            ready_q <= 1'b0;
            if (stream.byte_in == acc) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ST_ERR;
              error <= 1'b1;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeimem_loader.sv
// Directed bench for pipeimem_loader: expected writes are queued as bytes are
// driven and checked against each wr_en strobe.
`timescale 1ns/1ps
module tb_pipeimem_loader;
  import pipeimem_loader_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [6:0]  word_count;

  pipeimem_loader_if bus ();

  pipeimem_loader dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .stream     (bus),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          last_wr = 0;
  bit          gap_chk = 1'b0;
  bit          first_wr = 1'b1;
  logic [63:0] sb[$];
  logic [31:0] img[64];
  logic [31:0] mem[64];

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  initial begin
    #2ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pops the scoreboard on every write strobe and mirrors memory contents.
  task automatic monitor();
    logic [63:0] e;
    forever begin
      @(negedge clock);
      if (wr_en === 1'b1) begin
        total++;
        assert (sb.size() > 0) else begin
          bad++;
          $error("FAIL unexpected_write observed addr=%0h data=%0h expected none", wr_addr, wr_data);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("wr_addr", wr_addr, e[63:32]);
          chk("wr_data", wr_data, e[31:0]);
        end
        if (gap_chk && !first_wr) chk("wr_gap", 32'(cyc - last_wr), 32'd4);
        mem[wr_addr[7:2]] = wr_data;
        first_wr = 1'b0;
        last_wr  = cyc;
      end
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    int guard = 0;
    while (stall && $urandom_range(0, 2) == 0) begin
      bus.byte_valid = 1'b0;
      @(negedge clock);
    end
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (bus.byte_ready !== 1'b1) begin
      @(negedge clock);
      guard++;
      if (guard > 50) begin
        total++;
        bad++;
        $error("FAIL ready_timeout observed byte_ready=%b expected 1", bus.byte_ready);
        break;
      end
    end
    @(negedge clock);
    bus.byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Drives a frame of nw words from img; flip corrupts the checksum byte.
  task automatic run_frame(input logic [15:0] n, input int nw, input logic [7:0] flip, input bit stall);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    pulse_start();
    chk("ready_after_start", 32'(bus.byte_ready), 32'd1);
    chk("error_cleared", 32'(error), 32'd0);
    chk("hold_on_start", 32'(cpu_hold), 32'd1);
    first_wr = 1'b1;
    gap_chk  = !stall;
    send_byte(n[15:8], stall);
    send_byte(n[7:0], stall);
    for (int k = 0; k < nw; k++) begin
      for (int j = 0; j < 4; j++) begin
        b = img[k][31-8*j -: 8];
        if (j == 3) sb.push_back({32'(k << 2), img[k]});
        cs = cs ^ b;
        send_byte(b, stall);
      end
    end
    if (nw > 0) send_byte(cs ^ flip, stall);
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, wr_addr, 32'd0);
    chk({tag, "_wr_data"}, wr_data, 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_count"}, 32'(word_count), 32'd0);
    chk({tag, "_state"}, 32'(dut.state), 32'(ST_IDLE));
  endtask

  initial begin
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    fork monitor(); join_none

    repeat (2) @(negedge clock);
    chk_reset_values("por");
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("idle_hold", 32'(cpu_hold), 32'd1);
    chk("idle_ready", 32'(bus.byte_ready), 32'd0);

    // Nominal two-word image; checksum is computed from the data bytes.
    img[0] = 32'h2008_0005;
    img[1] = 32'hAC01_0004;
    run_frame(16'd2, 2, 8'h00, 1'b0);
    chk("nom_done", 32'(done), 32'd1);
    chk("nom_hold", 32'(cpu_hold), 32'd0);
    chk("nom_count", 32'(word_count), 32'd2);
    chk("nom_error", 32'(error), 32'd0);
    chk("nom_ready", 32'(bus.byte_ready), 32'd0);

    run_frame(16'd2, 2, 8'h01, 1'b0);
    chk("badcs_error", 32'(error), 32'd1);
    chk("badcs_hold", 32'(cpu_hold), 32'd1);
    chk("badcs_done", 32'(done), 32'd0);
    chk("badcs_ready", 32'(bus.byte_ready), 32'd0);
    chk("badcs_count", 32'(word_count), 32'd2);

    run_frame(16'h0000, 0, 8'h00, 1'b0);
    chk("len0_error", 32'(error), 32'd1);
    chk("len0_ready", 32'(bus.byte_ready), 32'd0);
    chk("len0_count", 32'(word_count), 32'd0);
    run_frame(16'h0041, 0, 8'h00, 1'b0);
    repeat (3) @(negedge clock);
    chk("len41_error", 32'(error), 32'd1);
    chk("len41_hold", 32'(cpu_hold), 32'd1);
    chk("len41_count", 32'(word_count), 32'd0);

    run_frame(16'd2, 2, 8'h00, 1'b0);
    chk("recover_done", 32'(done), 32'd1);
    chk("recover_error", 32'(error), 32'd0);

    mem[0] = 32'h0;
    mem[1] = 32'h0;
    run_frame(16'd2, 2, 8'h00, 1'b1);
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_mem0", mem[0], img[0]);
    chk("stall_mem1", mem[1], img[1]);

    // Reset after two bytes of the first word.
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(img[0][31:24], 1'b0);
    send_byte(img[0][23:16], 1'b0);
    reset = 1'b1;
    #1;
    chk_reset_values("midrst");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    chk("midrst_idle", 32'(dut.state), 32'(ST_IDLE));
    chk("midrst_sb", 32'(sb.size()), 32'd0);

    for (int k = 0; k < 64; k++) img[k] = $urandom;
    run_frame(16'd64, 64, 8'h00, 1'b0);
    chk("full_done", 32'(done), 32'd1);
    chk("full_count", 32'(word_count), 32'd64);
    chk("full_last_addr", wr_addr, 32'h0000_00FC);
    chk("full_last_data", wr_data, img[63]);
    chk("full_hold", 32'(cpu_hold), 32'd0);

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
